argmax_seq_ctrl: RTL and testbench
==================================

Name: argmax_seq_ctrl

Overview:
- Sequential classifier back-end: accepts the output-layer scores of the DNN one per cycle, and tracks the running maximum and its class index.
- Produces the final digit when the last score arrives.
- Sits between the output-layer neuron scheduler and the display/LED logic on the Nexys 4 DDR.
- Replaces the flat 10×8-bit combinational argmax with a streamed, handshaked version.

Parameters:
- N_CLASS, 10, number of scores per classification (digits 0..9).
- DATA_W, 8, score width; scores are unsigned.
- IDX_W, 4, index width; must satisfy 2^IDX_W >= N_CLASS.

Ports:
- iClk  input  1  system clock, all logic on rising edge.
- iRst_n  input  1  synchronous active-low reset.
- iStart  input  1  one-cycle pulse that begins a new classification.
- iScore  input  DATA_W  score of the class at the current stream position.
- iScore_valid  input  1  iScore is valid this cycle.
- iScore_last  input  1  marks the final score of the frame; qualified by iScore_valid.
- oScore_ready  output  1  block will accept a score this cycle.
- oBusy  output  1  classification in progress.
- oData_max  output  DATA_W  maximum score of the last completed frame.
- oIndex  output  IDX_W  class index of oData_max.
- oValid  output  1  one-cycle pulse when oData_max/oIndex update.
- oErr  output  1  sticky framing error flag; cleared by iStart or reset.

Behaviour:
- Reset (iRst_n=0 at clock edge):
  - State=IDLE; all outputs 0; internal count=0, run_max=0, run_idx=0.
  - Reset wins over any simultaneous input and aborts a frame mid-collection with no oValid.
- States: IDLE, COLLECT, DONE.
- IDLE:
  - oScore_ready=0, oBusy=0.
  - iStart -> COLLECT next cycle; clears count, run_max, run_idx and oErr.
  - Valid scores presented in IDLE are ignored (not accepted).
- COLLECT:
  - oScore_ready=1, oBusy=1.
  - A score is accepted on a cycle where iScore_valid && oScore_ready.
  - First accepted score (count=0): run_max<=iScore, run_idx<=0.
  - Later scores: if iScore > run_max (strict, unsigned), update run_max<=iScore and run_idx<=count. Ties keep the earlier (lower) index.
  - count increments per accepted score.
  - Gaps (iScore_valid=0) are allowed without limit.
- Frame end, on the accepted score where count==N_CLASS-1 or iScore_last=1, whichever occurs first:
  - Go to DONE.
  - Framing error, set oErr=1, if:
    - iScore_last=1 with count<N_CLASS-1 (short frame; the result is still computed over the received scores), or
    - count==N_CLASS-1 with iScore_last=0 (missing last).
- DONE (single cycle):
  - oData_max<=run_max and oIndex<=run_idx, including the final score's compare.
  - oValid=1 for exactly this cycle; oBusy=1, oScore_ready=0.
  - Next state is IDLE.
  - Latency: oValid is asserted the cycle after the final score is accepted.
- Result hold: oData_max/oIndex hold their values until the next DONE or reset.
- iStart while in COLLECT or DONE is ignored; no restart and no error.
- iStart and the final score arriving on the same cycle: the score is processed and iStart is dropped.
- Back-to-back operation: iStart may be pulsed in the IDLE cycle immediately after DONE, giving a minimum period of N_CLASS+2 cycles per frame.

Test Plan:
- Reset, then stream 10 scores (index 0 first) 0x2A,0x2E,0xE8,0x28,0xE8,0xA8,0x48,0xEA,0x55,0x00 with iScore_last on the 10th -> oValid pulse 1 cycle after the 10th score, oData_max=0xEA, oIndex=7, oErr=0.
- Tie case: all scores 0x40 except indices 3 and 6 = 0x90 -> oIndex=3, oData_max=0x90; repeat with all scores 0x00 -> oIndex=0, oData_max=0x00.
- Valid gaps: same frame as the first scenario with iScore_valid deasserted randomly between scores -> identical result; oScore_ready stays high throughout COLLECT.
- Short frame: iScore_last on the 4th score (0x10,0x80,0x20,0x30) -> DONE, oIndex=1, oData_max=0x80, oErr=1; next iStart clears oErr.
- Missing last: 10 scores with no iScore_last, max 0xFF at index 9 -> oIndex=9, oErr=1. Separately, iStart mid-frame -> ignored and the frame completes normally.
- Reset asserted after the 5th score -> no oValid; outputs are 0 the next cycle. A subsequent full frame classifies correctly. Two frames back-to-back produce oValid exactly N_CLASS+2 cycles apart.

Source files
------------

// File: rtl/argmax_seq_ctrl.sv
// Streamed argmax over the DNN output-layer scores: one score per cycle in,
// registered maximum score and its class index out, plus a sticky framing error.
module argmax_seq_ctrl #(
    parameter int N_CLASS = 10,
    parameter int DATA_W  = 8,
    parameter int IDX_W   = 4
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iStart,
    input  logic [DATA_W-1:0] iScore,
    input  logic              iScore_valid,
    input  logic              iScore_last,
    output logic              oScore_ready,
    output logic              oBusy,
    output logic [DATA_W-1:0] oData_max,
    output logic [IDX_W-1:0]  oIndex,
    output logic              oValid,
    output logic              oErr
);

    // state   | meaning
    // IDLE    | waiting for iStart, scores not accepted
    // COLLECT | accepting scores, tracking running max and index
    // DONE    | result registers just loaded, oValid pulse
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(N_CLASS - 1);

    logic [1:0]        state;
    logic [IDX_W-1:0]  count;
    logic [DATA_W-1:0] run_max;
    logic [IDX_W-1:0]  run_idx;

    logic              accept;
    logic              take_new;
    logic              at_full;
    logic              frame_end;
    logic              frame_err;
    logic [DATA_W-1:0] cand_max;
    logic [IDX_W-1:0]  cand_idx;

    always_comb begin
        accept    = (state == COLLECT) && iScore_valid;
        // strict compare keeps the lower index on ties
        take_new  = (count == '0) || (iScore > run_max);
        cand_max  = take_new ? iScore : run_max;
        cand_idx  = take_new ? count : run_idx;
        at_full   = (count == LAST_CNT);
        frame_end = accept && (iScore_last || at_full);
        frame_err = (iScore_last && !at_full) || (at_full && !iScore_last);
    end

    always_comb begin
        oScore_ready = (state == COLLECT);
        oBusy        = (state == COLLECT) || (state == DONE);
        oValid       = (state == DONE);
    end

    // the final score's compare is folded straight into the result registers
    // so they are already valid during the DONE cycle
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state     <= IDLE;
            count     <= '0;
            run_max   <= '0;
            run_idx   <= '0;
            oData_max <= '0;
            oIndex    <= '0;
            oErr      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iStart) begin
                        state   <= COLLECT;
                        count   <= '0;
                        run_max <= '0;
                        run_idx <= '0;
                        oErr    <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        run_max <= cand_max;
                        run_idx <= cand_idx;
                        count   <= count + 1'b1;
                        if (frame_end) begin
                            state     <= DONE;
                            oData_max <= cand_max;
                            oIndex    <= cand_idx;
                            oErr      <= oErr | frame_err;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_seq_ctrl.sv
// Scoreboard bench for argmax_seq_ctrl: driver pushes hand-computed results,
// a negedge monitor pops and compares whenever oValid is seen.
module tb_argmax_seq_ctrl;

    localparam int N_CLASS = 10;
    localparam int DATA_W  = 8;
    localparam int IDX_W   = 4;

    logic              iClk = 1'b0;
    logic              iRst_n = 1'b0;
    logic              iStart = 1'b0;
    logic [DATA_W-1:0] iScore = '0;
    logic              iScore_valid = 1'b0;
    logic              iScore_last = 1'b0;
    logic              oScore_ready;
    logic              oBusy;
    logic [DATA_W-1:0] oData_max;
    logic [IDX_W-1:0]  oIndex;
    logic              oValid;
    logic              oErr;

    argmax_seq_ctrl #(.N_CLASS(N_CLASS), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iScore(iScore),
        .iScore_valid(iScore_valid), .iScore_last(iScore_last),
        .oScore_ready(oScore_ready), .oBusy(oBusy), .oData_max(oData_max),
        .oIndex(oIndex), .oValid(oValid), .oErr(oErr)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [DATA_W-1:0] mx;
        logic [IDX_W-1:0]  idx;
        logic              err;
        int                cyc;
        bit                chk_period;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   last_valid_cyc = -1000;
    logic [DATA_W-1:0] fr [N_CLASS];

    always @(posedge iClk) cyc++;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge iClk) begin
        if (oValid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("data_max", int'(oData_max), int'(e.mx));
                chk("index", int'(oIndex), int'(e.idx));
                chk("err", int'(oErr), int'(e.err));
                chk("valid_latency", cyc, e.cyc);
                chk("busy_in_done", int'(oBusy), 1);
                if (e.chk_period)
                    chk("b2b_period", cyc - last_valid_cyc, N_CLASS + 2);
            end
            last_valid_cyc = cyc;
        end
    end

    task automatic do_start();
        @(posedge iClk); #1;
        iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        chk("busy_after_start", int'(oBusy), 1);
        chk("err_cleared_by_start", int'(oErr), 0);
    endtask

    // n scores; last_at = index carrying iScore_last (-1 for none);
    // start_at = index at which a stray iStart is driven (-1 for none)
    task automatic run_frame(input int n, input int last_at, input int start_at,
                             input bit gaps, input logic [DATA_W-1:0] emx,
                             input logic [IDX_W-1:0] eidx, input logic eerr,
                             input bit chk_period);
        exp_t e;
        do_start();
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    iScore_valid = 1'b0;
                    iScore       = 8'hFF;
                    iScore_last  = 1'b1;
                    @(posedge iClk); #1;
                    chk("ready_in_gap", int'(oScore_ready), 1);
                end
            end
            iScore       = fr[i];
            iScore_valid = 1'b1;
            iScore_last  = (i == last_at);
            iStart       = (i == start_at);
            if (i == n - 1) begin
                e.mx = emx; e.idx = eidx; e.err = eerr;
                e.cyc = cyc + 1; e.chk_period = chk_period;
                exp_q.push_back(e);
            end
            @(posedge iClk); #1;
        end
        iScore_valid = 1'b0;
        iScore_last  = 1'b0;
        iStart       = 1'b0;
        chk("ready_low_in_done", int'(oScore_ready), 0);
    endtask

    initial begin
        repeat (3) @(posedge iClk);
        #1;
        chk("rst_ready", int'(oScore_ready), 0);
        chk("rst_busy", int'(oBusy), 0);
        chk("rst_valid", int'(oValid), 0);
        chk("rst_max", int'(oData_max), 0);
        chk("rst_index", int'(oIndex), 0);
        chk("rst_err", int'(oErr), 0);
        iRst_n = 1'b1;

        // basic frame, then immediately back-to-back repeat
        fr = '{8'h2A, 8'h2E, 8'hE8, 8'h28, 8'hE8, 8'hA8, 8'h48, 8'hEA, 8'h55, 8'h00};
        run_frame(10, 9, -1, 0, 8'hEA, 4'd7, 1'b0, 0);
        run_frame(10, 9, -1, 0, 8'hEA, 4'd7, 1'b0, 1);

        // valid scores while idle must be ignored
        @(posedge iClk); #1;
        iScore = 8'hFF; iScore_valid = 1'b1; iScore_last = 1'b1;
        repeat (3) @(posedge iClk);
        #1;
        chk("idle_ready", int'(oScore_ready), 0);
        iScore_valid = 1'b0; iScore_last = 1'b0;

        fr = '{8'h40, 8'h40, 8'h40, 8'h90, 8'h40, 8'h40, 8'h90, 8'h40, 8'h40, 8'h40};
        run_frame(10, 9, -1, 0, 8'h90, 4'd3, 1'b0, 0);
        fr = '{default: 8'h00};
        run_frame(10, 9, -1, 0, 8'h00, 4'd0, 1'b0, 0);

        // gaps with junk data on the bus
        fr = '{8'h2A, 8'h2E, 8'hE8, 8'h28, 8'hE8, 8'hA8, 8'h48, 8'hEA, 8'h55, 8'h00};
        run_frame(10, 9, -1, 1, 8'hEA, 4'd7, 1'b0, 0);

        // short frame
        fr = '{8'h10, 8'h80, 8'h20, 8'h30, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_frame(4, 3, -1, 0, 8'h80, 4'd1, 1'b1, 0);
        @(posedge iClk); #1;
        chk("err_sticky_idle", int'(oErr), 1);

        // stray iStart mid-frame; do_start also checks that oErr clears
        fr = '{8'h2A, 8'h2E, 8'hE8, 8'h28, 8'hE8, 8'hA8, 8'h48, 8'hEA, 8'h55, 8'h00};
        run_frame(10, 9, 4, 0, 8'hEA, 4'd7, 1'b0, 0);

        // missing last, with iStart coinciding with the final score
        fr = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hFF};
        run_frame(10, -1, 9, 0, 8'hFF, 4'd9, 1'b1, 0);
        repeat (3) @(posedge iClk);
        #1;
        chk("no_restart_busy", int'(oBusy), 0);

        // reset after the 5th accepted score aborts the frame
        do_start();
        fr = '{8'h50, 8'h60, 8'h70, 8'h80, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 5; i++) begin
            iScore = fr[i]; iScore_valid = 1'b1;
            @(posedge iClk); #1;
        end
        iScore_valid = 1'b0;
        iRst_n = 1'b0;
        @(posedge iClk); #1;
        chk("abort_valid", int'(oValid), 0);
        chk("abort_max", int'(oData_max), 0);
        chk("abort_index", int'(oIndex), 0);
        chk("abort_busy", int'(oBusy), 0);
        chk("abort_ready", int'(oScore_ready), 0);
        chk("abort_err", int'(oErr), 0);
        iRst_n = 1'b1;
        repeat (2) @(posedge iClk);

        fr = '{8'h05, 8'h10, 8'h20, 8'hC0, 8'h30, 8'hC1, 8'h00, 8'h7F, 8'hC1, 8'h01};
        run_frame(10, 9, -1, 0, 8'hC1, 4'd5, 1'b0, 0);

        begin
            int waited = 0;
            while (exp_q.size() != 0 && waited < 30) begin
                @(posedge iClk);
                waited++;
            end
        end
        repeat (3) @(posedge iClk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
